// File: rtl/lt24_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : lt24_driver_if
// Desc     : Host pixel port plus ILI9341 8080-bus pins of the LT24 driver.
// Revision : 1.0
// ============================================================================
interface lt24_driver_if;
  logic [15:0] pixel_rgb;
  logic        print;
  logic        done;
  logic        initialized;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [15:0] lcd_data;
  logic        lcd_reset_n;
  logic        lcd_on;

  modport master (
    output pixel_rgb, print,
    input  done, initialized, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n,
           lcd_data, lcd_reset_n, lcd_on
  );

  modport slave (
    input  pixel_rgb, print,
    output done, initialized, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n,
           lcd_data, lcd_reset_n, lcd_on
  );
endinterface
`default_nettype wire

// File: rtl/lt24_driver.sv
`default_nettype none
// ============================================================================
// Module   : lt24_driver
// Desc     : ILI9341 (LT24) 8080 driver: power-up init ROM, then pixel writes.
// Revision : 1.0
// ============================================================================
module lt24_driver #(
  parameter int unsigned RESET_LOW_CYCLES  = 500,
  parameter int unsigned RESET_WAIT_CYCLES = 6000000,
  parameter int unsigned SLEEP_WAIT_CYCLES = 250000,
  parameter int unsigned WR_LOW_CYCLES     = 2,
  parameter int unsigned WR_HIGH_CYCLES    = 2,
  parameter int unsigned FRAME_PIXELS      = 76800
) (
  input  logic         clk,
  input  logic         reset,
  lt24_driver_if.slave bus
);

  localparam logic [3:0] ST_RST        = 4'd0;
  localparam logic [3:0] ST_HWRST_LOW  = 4'd1;
  localparam logic [3:0] ST_HWRST_WAIT = 4'd2;
  localparam logic [3:0] ST_INIT_LOAD  = 4'd3;
  localparam logic [3:0] ST_SLEEP_WAIT = 4'd4;
  localparam logic [3:0] ST_IDLE       = 4'd5;
  localparam logic [3:0] ST_FRAME_CMD  = 4'd6;
  localparam logic [3:0] ST_WR_LOW     = 4'd7;
  localparam logic [3:0] ST_WR_HIGH    = 4'd8;

  localparam logic [1:0] K_INIT  = 2'd0;
  localparam logic [1:0] K_FRAME = 2'd1;
  localparam logic [1:0] K_PIXEL = 2'd2;

  localparam logic [4:0] ROM_LAST = 5'd16;

  // {rs, data}: rs=0 command, rs=1 parameter data
  function automatic logic [16:0] rom_word(input logic [4:0] idx);
    case (idx)
      5'd0:    rom_word = {1'b0, 16'h0011};
      5'd1:    rom_word = {1'b0, 16'h003A};
      5'd2:    rom_word = {1'b1, 16'h0055};
      5'd3:    rom_word = {1'b0, 16'h0036};
      5'd4:    rom_word = {1'b1, 16'h0028};
      5'd5:    rom_word = {1'b0, 16'h002A};
      5'd6:    rom_word = {1'b1, 16'h0000};
      5'd7:    rom_word = {1'b1, 16'h0000};
      5'd8:    rom_word = {1'b1, 16'h0001};
      5'd9:    rom_word = {1'b1, 16'h003F};
      5'd10:   rom_word = {1'b0, 16'h002B};
      5'd11:   rom_word = {1'b1, 16'h0000};
      5'd12:   rom_word = {1'b1, 16'h0000};
      5'd13:   rom_word = {1'b1, 16'h0000};
      5'd14:   rom_word = {1'b1, 16'h00EF};
      5'd15:   rom_word = {1'b0, 16'h0029};
      default: rom_word = {1'b0, 16'h002C};
    endcase
  endfunction

  logic [3:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  kind_q, kind_d;
  logic [15:0] pix_q, pix_d;
  logic [16:0] pcnt_q, pcnt_d;
  logic        wrap_q, wrap_d;

  logic        cs_n_q, cs_n_d;
  logic        rs_q, rs_d;
  logic        wr_n_q, wr_n_d;
  logic [15:0] data_q, data_d;
  logic        rst_n_q, rst_n_d;
  logic        done_q, done_d;
  logic        init_q, init_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      kind_q  <= K_INIT;
      pix_q   <= '0;
      pcnt_q  <= '0;
      wrap_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rs_q    <= 1'b1;
      wr_n_q  <= 1'b1;
      data_q  <= '0;
      rst_n_q <= 1'b1;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
      pix_q   <= pix_d;
      pcnt_q  <= pcnt_d;
      wrap_q  <= wrap_d;
      cs_n_q  <= cs_n_d;
      rs_q    <= rs_d;
      wr_n_q  <= wr_n_d;
      data_q  <= data_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      init_q  <= init_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    idx_d   = idx_q;
    kind_d  = kind_q;
    pix_d   = pix_q;
    pcnt_d  = pcnt_q;
    wrap_d  = wrap_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_HWRST_LOW;
        cnt_d   = '0;
      end
      ST_HWRST_LOW: begin
        if (cnt_q == RESET_LOW_CYCLES - 1) begin
          state_d = ST_HWRST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_HWRST_WAIT: begin
        if (cnt_q == RESET_WAIT_CYCLES - 1) begin
          state_d = ST_INIT_LOAD;
          cnt_d   = '0;
        end
      end
      ST_INIT_LOAD: begin
        state_d = ST_WR_LOW;
        kind_d  = K_INIT;
        cnt_d   = '0;
      end
      ST_SLEEP_WAIT: begin
        if (cnt_q == SLEEP_WAIT_CYCLES - 1) begin
          state_d = ST_INIT_LOAD;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.print) begin
          pix_d = bus.pixel_rgb;
          // First pixel of a new frame re-issues memory-write to reset the panel's address pointer
          if (wrap_q && (pcnt_q == '0)) begin
            state_d = ST_FRAME_CMD;
            kind_d  = K_FRAME;
            wrap_d  = 1'b0;
          end else begin
            state_d = ST_WR_LOW;
            kind_d  = K_PIXEL;
          end
        end
      end
      ST_FRAME_CMD, ST_WR_LOW: begin
        if (cnt_q == WR_LOW_CYCLES - 1) begin
          state_d = ST_WR_HIGH;
          cnt_d   = '0;
        end
      end
      ST_WR_HIGH: begin
        if (cnt_q == WR_HIGH_CYCLES - 1) begin
          cnt_d = '0;
          case (kind_q)
            K_INIT: begin
              idx_d = idx_q + 5'd1;
              if (idx_q == 5'd0)          state_d = ST_SLEEP_WAIT;
              else if (idx_q == ROM_LAST) state_d = ST_IDLE;
              else                        state_d = ST_INIT_LOAD;
            end
            K_FRAME: begin
              state_d = ST_WR_LOW;
              kind_d  = K_PIXEL;
            end
            default: begin
              state_d = ST_IDLE;
              if (pcnt_q == 17'(FRAME_PIXELS - 1)) begin
                pcnt_d = '0;
                wrap_d = 1'b1;
              end else begin
                pcnt_d = pcnt_q + 17'd1;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so their next values are derived from the state being entered
  always_comb begin
    cs_n_d  = cs_n_q;
    rs_d    = rs_q;
    data_d  = data_q;
    wr_n_d  = !((state_d == ST_WR_LOW) || (state_d == ST_FRAME_CMD));
    rst_n_d = (state_d != ST_HWRST_LOW);
    done_d  = (state_q == ST_WR_HIGH) && (state_d == ST_IDLE) && (kind_q == K_PIXEL);
    init_d  = init_q || (state_d == ST_IDLE);
    if (state_d == ST_INIT_LOAD) begin
      cs_n_d         = 1'b0;
      {rs_d, data_d} = rom_word(idx_d);
    end else if ((state_q == ST_IDLE) && (state_d == ST_FRAME_CMD)) begin
      rs_d   = 1'b0;
      data_d = 16'h002C;
    end else if ((state_q == ST_IDLE) && (state_d == ST_WR_LOW)) begin
      rs_d   = 1'b1;
      data_d = bus.pixel_rgb;
    end else if ((state_q == ST_WR_HIGH) && (state_d == ST_WR_LOW)) begin
      rs_d   = 1'b1;
      data_d = pix_q;
    end
  end

  assign bus.lcd_cs_n    = cs_n_q;
  assign bus.lcd_rs      = rs_q;
  assign bus.lcd_wr_n    = wr_n_q;
  assign bus.lcd_rd_n    = 1'b1;
  assign bus.lcd_data    = data_q;
  assign bus.lcd_reset_n = rst_n_q;
  assign bus.lcd_on      = init_q;
  assign bus.done        = done_q;
  assign bus.initialized = init_q;

endmodule
`default_nettype wire

// File: tb/tb_lt24_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lt24_driver
// Desc     : Self-checking bench for lt24_driver with a bus-level write monitor.
// Revision : 1.0
// ============================================================================
module tb_lt24_driver;
  localparam int RL   = 4;
  localparam int RW   = 8;
  localparam int SW   = 8;
  localparam int WL   = 2;
  localparam int WH   = 1;
  localparam int FP   = 8;
  localparam int WCYC = WL + WH;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  lt24_driver_if bus();

  lt24_driver #(
    .RESET_LOW_CYCLES (RL),
    .RESET_WAIT_CYCLES(RW),
    .SLEEP_WAIT_CYCLES(SW),
    .WR_LOW_CYCLES    (WL),
    .WR_HIGH_CYCLES   (WH),
    .FRAME_PIXELS     (FP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pix    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] init_words [17] = '{
    {1'b0, 16'h0011}, {1'b0, 16'h003A}, {1'b1, 16'h0055}, {1'b0, 16'h0036},
    {1'b1, 16'h0028}, {1'b0, 16'h002A}, {1'b1, 16'h0000}, {1'b1, 16'h0000},
    {1'b1, 16'h0001}, {1'b1, 16'h003F}, {1'b0, 16'h002B}, {1'b1, 16'h0000},
    {1'b1, 16'h0000}, {1'b1, 16'h0000}, {1'b1, 16'h00EF}, {1'b0, 16'h0029},
    {1'b0, 16'h002C}
  };

  // Bus monitor: every wr_n falling edge is one write {rs, data}
  logic [16:0] wq [$];
  int          wt [$];
  int          dq [$];
  int          rstlow_cnt = 0;
  int          stab_err   = 0;
  logic        prev_wr_n  = 1'b1;
  logic [16:0] cap        = '0;

  always @(negedge clk) begin
    prev_wr_n <= bus.lcd_wr_n;
    if (prev_wr_n && !bus.lcd_wr_n) begin
      wq.push_back({bus.lcd_rs, bus.lcd_data});
      wt.push_back(cyc);
      cap <= {bus.lcd_rs, bus.lcd_data};
    end else if (!prev_wr_n && !reset && ({bus.lcd_rs, bus.lcd_data} !== cap)) begin
      stab_err <= stab_err + 1;
    end
    if (bus.done) dq.push_back(cyc);
    if (!bus.lcd_reset_n) rstlow_cnt <= rstlow_cnt + 1;
  end

  task automatic test_reset;
    reset         = 1'b1;
    bus.print     = 1'b0;
    bus.pixel_rgb = 16'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rs, bus.lcd_reset_n} !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 11111",
               {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rs, bus.lcd_reset_n});
    end
    n_checks++;
    if (bus.lcd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0000", bus.lcd_data);
    end
    n_checks++;
    if ({bus.lcd_on, bus.done, bus.initialized} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_status: got %b expected 000", {bus.lcd_on, bus.done, bus.initialized});
    end
  endtask

  task automatic test_init;
    int w0, d0, r0, s0, exp_gap;
    bit ok;
    w0 = wq.size();
    d0 = dq.size();
    r0 = rstlow_cnt;
    s0 = stab_err;
    @(negedge clk);
    reset = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (bus.initialized) begin
        ok        = 1'b1;
        bus.print = 1'b0;
      end else begin
        bus.print     = 1'($urandom_range(0, 1));
        bus.pixel_rgb = 16'($urandom);
      end
    end
    bus.print = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL init_timeout: initialized=%b expected 1 within 400 cycles", bus.initialized);
    end
    n_checks++;
    if (rstlow_cnt - r0 !== RL) begin
      n_fail++;
      $display("FAIL init_reset_low: got %0d cycles expected %0d", rstlow_cnt - r0, RL);
    end
    n_checks++;
    if (wq.size() - w0 !== 17) begin
      n_fail++;
      $display("FAIL init_write_count: got %0d expected 17", wq.size() - w0);
    end else begin
      for (int k = 0; k < 17; k++) begin
        n_checks++;
        if (wq[w0+k] !== init_words[k]) begin
          n_fail++;
          $display("FAIL init_word%0d: got %h expected %h", k, wq[w0+k], init_words[k]);
        end
      end
      for (int k = 0; k < 16; k++) begin
        // each word: load cycle + write cycle; the sleep-out command adds the sleep wait
        exp_gap = (k == 0) ? (WCYC + 1 + SW) : (WCYC + 1);
        n_checks++;
        if (wt[w0+k+1] - wt[w0+k] !== exp_gap) begin
          n_fail++;
          $display("FAIL init_gap%0d: got %0d expected %0d", k, wt[w0+k+1] - wt[w0+k], exp_gap);
        end
      end
    end
    n_checks++;
    if ({bus.initialized, bus.lcd_on, bus.lcd_cs_n, bus.lcd_rd_n} !== 4'b1101) begin
      n_fail++;
      $display("FAIL init_status: got %b expected 1101",
               {bus.initialized, bus.lcd_on, bus.lcd_cs_n, bus.lcd_rd_n});
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ((dq.size() - d0 !== 0) || (wq.size() - w0 !== 17)) begin
      n_fail++;
      $display("FAIL init_no_extra: got done=%0d writes=%0d expected 0 and 17",
               dq.size() - d0, wq.size() - w0);
    end
    n_checks++;
    if (stab_err - s0 !== 0) begin
      n_fail++;
      $display("FAIL init_stability: got %0d unstable cycles expected 0", stab_err - s0);
    end
  endtask

  task automatic test_single(input logic [15:0] pix);
    logic exp_wr, exp_done;
    repeat (2) @(negedge clk);
    bus.print     = 1'b1;
    bus.pixel_rgb = pix;
    for (int k = 1; k <= WCYC + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.print     = 1'b0;
        bus.pixel_rgb = ~pix;
      end
      exp_wr   = (k <= WL) ? 1'b0 : 1'b1;
      exp_done = (k == WCYC + 1);
      n_checks++;
      if ({bus.lcd_data, bus.lcd_rs, bus.lcd_wr_n, bus.done} !== {pix, 1'b1, exp_wr, exp_done}) begin
        n_fail++;
        $display("FAIL single_t+%0d: got data=%h rs=%b wr_n=%b done=%b expected data=%h rs=1 wr_n=%b done=%b",
                 k, bus.lcd_data, bus.lcd_rs, bus.lcd_wr_n, bus.done, pix, exp_wr, exp_done);
      end
    end
    n_pix++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] p [3];
    int w0, d0, t0;
    for (int i = 0; i < 3; i++) p[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    w0 = wq.size();
    d0 = dq.size();
    bus.print     = 1'b1;
    bus.pixel_rgb = p[0];
    t0 = cyc;
    for (int c = 1; c <= 3 * (WCYC + 1) + 3; c++) begin
      @(negedge clk);
      if ((c % (WCYC + 1) == 0) && (c / (WCYC + 1) < 3)) bus.pixel_rgb = p[c / (WCYC + 1)];
      if (c == 2 * (WCYC + 1) + 1) bus.print = 1'b0;
    end
    n_checks++;
    if (dq.size() - d0 !== 3 || wq.size() - w0 !== 3) begin
      n_fail++;
      $display("FAIL b2b_counts: got done=%0d writes=%0d expected 3 and 3", dq.size() - d0, wq.size() - w0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (dq[d0+i] - t0 !== (WCYC + 1) * (i + 1)) begin
          n_fail++;
          $display("FAIL b2b_done%0d: got t+%0d expected t+%0d", i, dq[d0+i] - t0, (WCYC + 1) * (i + 1));
        end
        n_checks++;
        if (wq[w0+i] !== {1'b1, p[i]}) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h expected %h", i, wq[w0+i], {1'b1, p[i]});
        end
      end
    end
    n_pix += 3;
  endtask

  task automatic test_ignore_during_write;
    logic [15:0] p;
    int w0, d0, t;
    p = 16'($urandom);
    repeat (2) @(negedge clk);
    w0 = wq.size();
    d0 = dq.size();
    bus.print     = 1'b1;
    bus.pixel_rgb = p;
    t = cyc;
    @(negedge clk);
    bus.print     = 1'b1;
    bus.pixel_rgb = ~p;
    @(negedge clk);
    bus.print = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (wq.size() - w0 !== 1 || dq.size() - d0 !== 1) begin
      n_fail++;
      $display("FAIL ignore_counts: got writes=%0d done=%0d expected 1 and 1", wq.size() - w0, dq.size() - d0);
    end else begin
      n_checks++;
      if (wq[w0] !== {1'b1, p} || dq[d0] - t !== WCYC + 1) begin
        n_fail++;
        $display("FAIL ignore_write: got %h done t+%0d expected %h done t+%0d",
                 wq[w0], dq[d0] - t, {1'b1, p}, WCYC + 1);
      end
    end
    n_pix++;
  endtask

  task automatic test_frame_wrap;
    logic [16:0] exp_w [$];
    logic [15:0] p;
    int w0, d0, t, n_fill;
    bit need_cmd;
    w0 = wq.size();
    d0 = dq.size();
    n_fill = 0;
    while (n_pix % FP != 0) begin
      repeat (2) @(negedge clk);
      bus.print     = 1'b1;
      bus.pixel_rgb = 16'($urandom);
      @(negedge clk);
      bus.print = 1'b0;
      repeat (WCYC + 2) @(negedge clk);
      n_pix++;
      n_fill++;
    end
    n_checks++;
    if (wq.size() - w0 !== n_fill || dq.size() - d0 !== n_fill) begin
      n_fail++;
      $display("FAIL frame_fill: got writes=%0d done=%0d expected %0d", wq.size() - w0, dq.size() - d0, n_fill);
    end
    need_cmd = (n_pix != 0) && (n_pix % FP == 0);
    p = 16'($urandom);
    if (need_cmd) exp_w.push_back({1'b0, 16'h002C});
    exp_w.push_back({1'b1, p});
    repeat (2) @(negedge clk);
    w0 = wq.size();
    d0 = dq.size();
    bus.print     = 1'b1;
    bus.pixel_rgb = p;
    t = cyc;
    @(negedge clk);
    bus.print     = 1'b0;
    bus.pixel_rgb = ~p;
    repeat (2 * WCYC + 4) @(negedge clk);
    n_checks++;
    if (wq.size() - w0 !== exp_w.size() || dq.size() - d0 !== 1) begin
      n_fail++;
      $display("FAIL frame_counts: got writes=%0d done=%0d expected %0d and 1",
               wq.size() - w0, dq.size() - d0, exp_w.size());
    end else begin
      for (int i = 0; i < exp_w.size(); i++) begin
        n_checks++;
        if (wq[w0+i] !== exp_w[i] || wt[w0+i] - t !== 1 + WCYC * i) begin
          n_fail++;
          $display("FAIL frame_write%0d: got %h at t+%0d expected %h at t+%0d",
                   i, wq[w0+i], wt[w0+i] - t, exp_w[i], 1 + WCYC * i);
        end
      end
      n_checks++;
      if (dq[d0] - t !== 1 + WCYC * exp_w.size()) begin
        n_fail++;
        $display("FAIL frame_done: got t+%0d expected t+%0d", dq[d0] - t, 1 + WCYC * exp_w.size());
      end
    end
    n_pix++;
  endtask

  task automatic test_reset_midwrite;
    repeat (2) @(negedge clk);
    bus.print     = 1'b1;
    bus.pixel_rgb = 16'($urandom);
    @(negedge clk);
    bus.print = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rs, bus.lcd_reset_n,
         bus.lcd_on, bus.done, bus.initialized} !== 8'b11111000) begin
      n_fail++;
      $display("FAIL midwrite_ctrl: got %b expected 11111000",
               {bus.lcd_cs_n, bus.lcd_wr_n, bus.lcd_rd_n, bus.lcd_rs, bus.lcd_reset_n,
                bus.lcd_on, bus.done, bus.initialized});
    end
    n_checks++;
    if (bus.lcd_data !== 16'h0) begin
      n_fail++;
      $display("FAIL midwrite_data: got %h expected 0000", bus.lcd_data);
    end
    n_pix = 0;
    test_init();
    test_single(16'($urandom));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.print     = 1'b0;
    bus.pixel_rgb = 16'h0;
    test_reset();
    test_init();
    test_single(16'hF800);
    test_back_to_back();
    test_ignore_during_write();
    test_frame_wrap();
    test_single(16'($urandom));
    test_reset_midwrite();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
